// File: rtl/cube_input_pkg.sv
// Shared types and board timing defaults for the cube-state input front end.
package cube_input_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } flash_state_e;

  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned FLASH_ON_MS  = 100;
  localparam int unsigned FLASH_OFF_MS = 100;

  localparam int unsigned DEFAULT_ON_CYCLES  = (CLK_HZ / 1000) * FLASH_ON_MS;
  localparam int unsigned DEFAULT_OFF_CYCLES = (CLK_HZ / 1000) * FLASH_OFF_MS;
  localparam int unsigned DEFAULT_MAX_PENDING = 7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_led_flasher.sv
// Stretches 1-cycle event pulses into visible LED flashes with a fixed OFF gap,
// queueing events that arrive mid-flash in a saturating counter.
module pulse_led_flasher
  import cube_input_pkg::*;
#(
  parameter int unsigned ON_CYCLES   = DEFAULT_ON_CYCLES,
  parameter int unsigned OFF_CYCLES  = DEFAULT_OFF_CYCLES,
  parameter int unsigned MAX_PENDING = DEFAULT_MAX_PENDING
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               pulse_in,
  output logic                               led,
  output logic                               busy,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
  output logic                               dropped
);

  localparam int unsigned PW     = $clog2(MAX_PENDING + 1);
  localparam int unsigned TW_RAW = $clog2(max_u(ON_CYCLES, OFF_CYCLES));
  localparam int unsigned TW     = (TW_RAW > 0) ? TW_RAW : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  flash_state_e  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] pending_q, pending_d;
  logic          led_q, led_d;
  logic          busy_q, busy_d;
  logic          dropped_q, dropped_d;
  logic          enqueue;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;
    led_d     = led_q;
    dropped_d = 1'b0;
    enqueue   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        led_d = 1'b0;
        if (pulse_in) begin
          state_d = ST_ON;
          led_d   = 1'b1;
          timer_d = ON_LOAD;
        end
      end
      ST_ON: begin
        enqueue = pulse_in;
        if (timer_q == '0) begin
          state_d = ST_OFF;
          led_d   = 1'b0;
          timer_d = OFF_LOAD;
        end else begin
          led_d   = 1'b1;
          timer_d = timer_q - 1'b1;
        end
      end
      ST_OFF: begin
        led_d = 1'b0;
        if (timer_q != '0) begin
          enqueue = pulse_in;
          timer_d = timer_q - 1'b1;
        end else if ((pending_q != '0) || pulse_in) begin
          // Dequeue and a same-cycle pulse cancel out; this path never saturates.
          state_d   = ST_ON;
          led_d     = 1'b1;
          timer_d   = ON_LOAD;
          pending_d = pending_q + PW'(pulse_in) - 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = 1'b0;
        timer_d = '0;
      end
    endcase

    if (enqueue) begin
      if (pending_q < PEND_MAX) begin
        pending_d = pending_q + 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      pending_q <= '0;
      led_q     <= 1'b0;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign led     = led_q;
  assign busy    = busy_q;
  assign pending = pending_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_led_flasher.sv
// Directed bench for pulse_led_flasher with ON=4, OFF=3, MAX_PENDING=3.
module tb_pulse_led_flasher;

  localparam int unsigned ON   = 4;
  localparam int unsigned OFF  = 3;
  localparam int unsigned MAXP = 3;
  localparam int unsigned PW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse_in = 1'b0;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          dropped;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;

  pulse_led_flasher #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pulse_in(pulse_in),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  // Drive pulse_in for one edge, then sample 1 time unit after that edge.
  task automatic step(input logic p);
    pulse_in = p;
    @(posedge clk);
    #1;
    pulse_in = 1'b0;
  endtask

  task automatic check(input string tag, input int j, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s j=%0d observed=%0d expected=%0d", tag, j, obs, exp);
    end
  endtask

  task automatic chk(input string tn, input int j, input logic e_led, input logic e_busy,
                     input int unsigned e_pend, input logic e_drop);
    check({tn, ".led"},     j, 32'(led),     32'(e_led));
    check({tn, ".busy"},    j, 32'(busy),    32'(e_busy));
    check({tn, ".pending"}, j, 32'(pending), e_pend);
    check({tn, ".dropped"}, j, 32'(dropped), 32'(e_drop));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0);
    rst_n = 1'b1;
    step(1'b0);
  endtask

  initial begin
    int rises;
    logic prev_led;
    int unsigned ep;

    // Reset state
    rst_n = 1'b0;
    step(1'b1);
    chk("reset", 0, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    step(1'b0);
    chk("reset_idle", 1, 1'b0, 1'b0, 0, 1'b0);

    // 1: single pulse
    for (int j = 0; j <= 9; j++) begin
      step(j == 0);
      chk("single", j, (j <= 3), (j <= 6), 0, 1'b0);
    end

    // 2: two pulses, second queued
    do_reset();
    for (int j = 0; j <= 15; j++) begin
      step((j == 0) || (j == 2));
      chk("two", j, (j <= 3) || (j >= 7 && j <= 10), (j <= 13),
          ((j >= 2) && (j <= 6)) ? 1 : 0, 1'b0);
    end

    // 3: saturation with held pulse_in
    do_reset();
    rises = 0;
    prev_led = 1'b0;
    for (int j = 0; j <= 31; j++) begin
      step((j == 0) || (j >= 2 && j <= 6));
      if (j < 2)       ep = 0;
      else if (j <= 6) ep = (j - 1 > 3) ? 3 : j - 1;
      else if (j <= 13) ep = 2;
      else if (j <= 20) ep = 1;
      else             ep = 0;
      chk("sat", j, ((j % 7) <= 3) && (j <= 24), (j <= 27), ep, (j == 5) || (j == 6));
      if (led && !prev_led) rises++;
      prev_led = led;
    end
    check("sat.flash_count", 0, 32'(rises), 32'd4);

    // 4: pulse coinciding with the final OFF edge while one is queued
    do_reset();
    for (int j = 0; j <= 23; j++) begin
      step((j == 0) || (j == 2) || (j == 7));
      chk("coincide", j, ((j % 7) <= 3) && (j <= 17), (j <= 20),
          ((j >= 2) && (j <= 13)) ? 1 : 0, 1'b0);
    end

    // 5: reset mid-flash with pending=2
    do_reset();
    step(1'b1);
    chk("midrst", 0, 1'b1, 1'b1, 0, 1'b0);
    step(1'b1);
    chk("midrst", 1, 1'b1, 1'b1, 1, 1'b0);
    step(1'b1);
    chk("midrst", 2, 1'b1, 1'b1, 2, 1'b0);
    rst_n = 1'b0;
    step(1'b0);
    chk("midrst", 3, 1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    step(1'b0);
    chk("midrst", 4, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1);
    chk("midrst", 5, 1'b1, 1'b1, 0, 1'b0);
    step(1'b0);
    chk("midrst", 6, 1'b1, 1'b1, 0, 1'b0);

    // 6: pulse on the ON->OFF transition edge
    do_reset();
    for (int j = 0; j <= 15; j++) begin
      step((j == 0) || (j == 4));
      chk("onoff_edge", j, (j <= 3) || (j >= 7 && j <= 10), (j <= 13),
          ((j >= 4) && (j <= 6)) ? 1 : 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
